// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide sequencer.
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: fixed-latency multiply, iterative restoring divide,
// single-cycle divide-by-zero / signed-overflow results, flushable from any state.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      fn_q, fn_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    // Multiply on the captured operands; the extra two guard bits let one unsigned
    // multiplier serve all four signedness combinations.
    logic            mul_a_signed, mul_b_signed;
    logic [2*XLEN+1:0] mul_a, mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0] mul_res;

    always_comb begin
        mul_a_signed = (fn_q == 3'd1) || (fn_q == 3'd2);
        mul_b_signed = (fn_q == 3'd1);
        mul_a        = {{(XLEN+2){mul_a_signed & a_q[XLEN-1]}}, a_q};
        mul_b        = {{(XLEN+2){mul_b_signed & b_q[XLEN-1]}}, b_q};
        mul_prod     = (2*XLEN)'(mul_a * mul_b);
        mul_res      = (fn_q == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // One restoring step on magnitudes, then sign fix-up of the final pair.
    logic [XLEN:0]   rem_sh;
    logic            fits;
    logic [XLEN-1:0] rem_step, quo_step;
    logic            div_signed;
    logic [XLEN-1:0] quo_fix, rem_fix, div_res;

    always_comb begin
        rem_sh     = {rem_q, quo_q[XLEN-1]};
        fits       = rem_sh >= {1'b0, dvs_q};
        rem_step   = fits ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
        quo_step   = {quo_q[XLEN-2:0], fits};
        div_signed = ~fn_q[0];
        quo_fix    = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
        rem_fix    = (div_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
        div_res    = fn_q[1] ? rem_fix : quo_fix;
    end

    // Classification of a new request straight from the request inputs.
    logic            in_div, in_signed, div_zero, div_ovf;
    logic [XLEN-1:0] special_res, abs_a, abs_b;

    always_comb begin
        in_div      = bus.funct3_i[2];
        in_signed   = ~bus.funct3_i[0];
        div_zero    = (bus.rs2_i == '0);
        div_ovf     = in_signed && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2_i);
        if (div_zero) special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        else          special_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
        abs_a       = (in_signed && bus.rs1_i[XLEN-1]) ? -bus.rs1_i : bus.rs1_i;
        abs_b       = (in_signed && bus.rs2_i[XLEN-1]) ? -bus.rs2_i : bus.rs2_i;
    end

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block infers a latch.
        state_d  = state_q;
        fn_d     = fn_q;
        a_d      = a_q;
        b_d      = b_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        fn_d = bus.funct3_i;
                        a_d  = bus.rs1_i;
                        b_d  = bus.rs2_i;
                        if (!in_div) begin
                            state_d = S_MUL;
                        end else if (div_zero || div_ovf) begin
                            state_d  = S_DONE;
                            result_d = special_res;
                            done_d   = 1'b1;
                        end else begin
                            state_d = S_DIV;
                            rem_d   = '0;
                            quo_d   = abs_a;
                            dvs_d   = abs_b;
                            cnt_d   = CNT_W'(XLEN-1);
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    state_d  = S_DONE;
                    result_d = mul_res;
                    done_d   = 1'b1;
                end
                S_DIV: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d  = S_DONE;
                    result_d = div_res;
                    done_d   = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: reset is sampled on the clock edge and state updates use <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fn_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences RV32M multiply/divide operations for the core execute stage.
- Multiply completes at fixed latency. Divide uses an iterative restoring shift-subtract datapath owned by this block.
- Handles the divide-by-zero and signed-overflow special cases without iterating.
- busy_o stalls the pipeline while an operation is in flight; done_o pulses when result_o is valid for writeback.

Parameters:
XLEN, 32, operand/result width; also the divide iteration count.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start_i  input  1  request; sampled only in IDLE or DONE
funct3_i  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  input  XLEN  operand A / dividend
rs2_i  input  XLEN  operand B / divisor
flush_i  input  1  abort in-flight operation
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  XLEN  result; holds until the next completed operation

Behaviour:
- Reset (rst=1 at an edge, in any state): state=IDLE, result_o=0, done_o=0, busy_o=0, iteration counter=0, operand/remainder/quotient registers=0. Reset in the middle of a divide discards that divide.
- States: IDLE, MUL, DIV, FIX, DONE.
- Operand capture: at the accepting edge the block latches funct3, rs1 and rs2. start_i is ignored in MUL, DIV and FIX.
- From IDLE or DONE with start_i=1:
  - funct3<4 goes to MUL.
  - funct3>=4 with divisor=0 or signed overflow goes to DONE (special-case path).
  - Any other funct3>=4 goes to DIV.
  - DONE with start_i=0 goes to IDLE.
- MUL:
  - Sign/zero-extend operands to 2*XLEN+2 bits. rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only.
  - MUL returns the low XLEN bits; the others return bits [2*XLEN-1:XLEN].
  - Next state DONE.
  - Latency: done_o is high in the cycle after edge N+2, where N is the accepting edge.
- DIV:
  - DIV/REM take absolute values of both operands; DIVU/REMU use them raw.
  - Each cycle: shift the {remainder, quotient} pair left by 1. If the remainder is >= the divisor, subtract the divisor and set quotient bit 0 to 1.
  - Counter runs XLEN-1 down to 0; at 0 the next state is FIX.
- FIX:
  - Signed ops only: negate the quotient if the operand signs differ; negate the remainder if rs1 is negative.
  - Select quotient or remainder per funct3. Next state DONE.
- Divide latency: done_o in the cycle after edge N+XLEN+2 (34 for XLEN=32).
- Special cases (latency 1, done_o after edge N+1):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: done_o=1 and result_o updated on entry. If start_i=1 in DONE, the new op is accepted, giving back-to-back operation with busy_o staying high.
- flush_i:
  - In any non-IDLE state, the next state is IDLE with no done_o pulse; result_o is unchanged.
  - flush_i has priority over start_i in the same cycle, including in IDLE and DONE.
  - Flush in the DONE cycle: the done pulse already asserted stands; the next state is IDLE.
- rst has priority over flush_i and start_i.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result_o=0xFFFFFFEB; done_o exactly 2 cycles after the accepting edge; busy_o high for 2 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done_o exactly 34 cycles after acceptance.
- Divide-by-zero and overflow, each with done_o 1 cycle after acceptance:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Abort and busy handling:
  - flush_i on the 10th DIV cycle: busy_o=0 next cycle, no done_o, result_o keeps its prior value.
  - A start_i held high during busy is ignored.
  - A new DIVU 9/3 issued right after the flush -> 3 after 34 cycles.
- Back-to-back and reset:
  - start_i in the DONE cycle of a MUL launches a DIVU 20/4 -> 5 with busy_o continuous.
  - rst asserted mid-DIV: next cycle busy_o=0, result_o=0, done_o=0.
